// File: rtl/pipeline_reg_memwb_skid.sv
// MEM->WB pipeline register with a 2-entry skid buffer (head H, skid S) and registered in_ready.
// Optional forwarding taps are enabled by defining MEMWB_FWD_EN.
module pipeline_reg_memwb_skid #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic [XLEN-1:0]       in_mem_out,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_mem_to_reg,
  input  logic                  in_write_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_alu_out,
  output logic [XLEN-1:0]       out_mem_out,
  output logic [XLEN-1:0]       out_wb_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_mem_to_reg,
  output logic                  out_write_enable
`ifdef MEMWB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       mem;
    logic [REG_ADDR_W-1:0] rd;
    logic                  m2r;
    logic                  we;
  } entry_t;

  entry_t h_q, h_d, s_q, s_d, in_entry;
  logic   in_ready_q, in_ready_d;
  logic   accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = h_q.valid & out_ready;

  // Writes to x0 are squashed at capture so the strobe never needs an rd compare downstream.
  always_comb begin
    in_entry.valid = 1'b1;
    in_entry.alu   = in_alu_out;
    in_entry.mem   = in_mem_out;
    in_entry.rd    = in_rd;
    in_entry.m2r   = in_mem_to_reg;
    in_entry.we    = in_write_enable & (in_rd != '0);
  end

  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (flush) begin
      h_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else if (s_q.valid) begin
      // Full: in_ready is already low, so only a pop can change state.
      if (pop) begin
        h_d       = s_q;
        s_d.valid = 1'b0;
      end
    end else if (h_q.valid) begin
      if (pop && accept) begin
        h_d = in_entry;
      end else if (pop) begin
        h_d.valid = 1'b0;
      end else if (accept) begin
        s_d = in_entry;
      end
    end else if (accept) begin
      h_d = in_entry;
    end
    in_ready_d = ~s_d.valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      h_q        <= h_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = h_q.valid;
  assign out_alu_out      = h_q.alu;
  assign out_mem_out      = h_q.mem;
  assign out_wb_data      = h_q.m2r ? h_q.mem : h_q.alu;
  assign out_rd           = h_q.rd;
  assign out_mem_to_reg   = h_q.m2r;
  assign out_write_enable = h_q.valid & h_q.we;

`ifdef MEMWB_FWD_EN
  assign fwd_valid = h_q.valid & h_q.we;
  assign fwd_rd    = h_q.rd;
  assign fwd_data  = out_wb_data;
`endif

endmodule

// File: tb/tb_pipeline_reg_memwb_skid.sv
// Self-checking bench for pipeline_reg_memwb_skid: directed scenarios plus a randomized run
// checked against a queue-based model of the 2-entry FIFO stage.
module tb_pipeline_reg_memwb_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [31:0] in_mem_out;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_write_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_out;
  logic [31:0] out_mem_out;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_mem_to_reg;
  logic        out_write_enable;
`ifdef MEMWB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_reg_memwb_skid #(
    .XLEN      (32),
    .REG_ADDR_W(5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_alu_out      (in_alu_out),
    .in_mem_out      (in_mem_out),
    .in_rd           (in_rd),
    .in_mem_to_reg   (in_mem_to_reg),
    .in_write_enable (in_write_enable),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alu_out     (out_alu_out),
    .out_mem_out     (out_mem_out),
    .out_wb_data     (out_wb_data),
    .out_rd          (out_rd),
    .out_mem_to_reg  (out_mem_to_reg),
    .out_write_enable(out_write_enable)
`ifdef MEMWB_FWD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic m2r, input logic we);
    in_valid        = v;
    in_alu_out      = alu;
    in_mem_out      = mem;
    in_rd           = rd;
    in_mem_to_reg   = m2r;
    in_write_enable = we;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b1);
      flush     = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, out_write_enable, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL reset_ctrl: valid/we/ready got %b, want 001",
                 {out_valid, out_write_enable, in_ready});
      end
      checks++;
      if ({out_alu_out, out_mem_out, out_wb_data, out_rd, out_mem_to_reg} !== '0) begin
        errors++;
        $display("FAIL reset_data: alu=%h mem=%h wb=%h rd=%0d m2r=%b, want all 0",
                 out_alu_out, out_mem_out, out_wb_data, out_rd, out_mem_to_reg);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(i), $urandom, 5'(i + 1), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'(i + 1) || out_wb_data !== 32'h10 + 32'(i) ||
          in_ready !== 1'b1 || out_write_enable !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b rd=%0d wb=%h ready=%b we=%b, want 1 %0d %h 1 1",
                 i, out_valid, out_rd, out_wb_data, in_ready, out_write_enable, i + 1,
                 32'h10 + 32'(i));
      end
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b we=%b, want 0 0", out_valid, out_write_enable);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111, 32'hAA, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_wb_data !== 32'hAA || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a_head: valid=%b rd=%0d wb=%h ready=%b, want 1 5 aa 1",
               out_valid, out_rd, out_wb_data, in_ready);
    end
    drive(1'b1, 32'hBB, 32'h2222, 5'd6, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hDEAD, 32'hBEEF, 5'd9, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || out_rd !== 5'd5) begin
      errors++;
      $display("FAIL bp_full: ready=%b rd=%0d, want 0 5", in_ready, out_rd);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_rd !== 5'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: ready=%b rd=%0d valid=%b, want 0 5 1", in_ready, out_rd, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_wb_data !== 32'hBB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_b_head: valid=%b rd=%0d wb=%h ready=%b, want 1 6 bb 1",
               out_valid, out_rd, out_wb_data, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b, want 0 (no extra entry)", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h80, 32'h0, 5'd8, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h90, 32'h0, 5'd9, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hC0, 32'h0, 5'd10, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: valid=%b ready=%b we=%b, want 0 1 0",
               out_valid, in_ready, out_write_enable);
    end
    // Flush with one entry held while a new entry is being accepted.
    drive(1'b1, 32'hF0, 32'h0, 5'd11, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hC1, 32'h0, 5'd12, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost_%0d: valid=%b rd=%0d, want valid 0", i, out_valid, out_rd);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_x0_write();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 32'h0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_write_enable !== 1'b0 || out_rd !== 5'd0) begin
      errors++;
      $display("FAIL x0_write: valid=%b we=%b rd=%0d, want 1 0 0",
               out_valid, out_write_enable, out_rd);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef MEMWB_FWD_EN
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h1234) begin
      errors++;
      $display("FAIL fwd_head: fwd_valid=%b rd=%0d data=%h, want 1 7 1234",
               fwd_valid, fwd_rd, fwd_data);
    end
`endif
    checks++;
    if (out_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: we=%b, want 1", out_write_enable);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_write_enable !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: valid=%b we=%b ready=%b, want 0 0 1",
               out_valid, out_write_enable, in_ready);
    end
`ifdef MEMWB_FWD_EN
    checks++;
    if (fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_reset: fwd_valid=%b, want 0", fwd_valid);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        m2r;
    logic        we;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t last;
    ent_t hd;
    ent_t e;
    logic acc;
    logic pp;
    logic [31:0] exp_wb;
    pulse_reset();
    last = '{alu: 32'h0, mem: 32'h0, rd: 5'd0, m2r: 1'b0, we: 1'b0};
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      hd = (q.size() > 0) ? q[0] : last;
      exp_wb = hd.m2r ? hd.mem : hd.alu;
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          out_write_enable !== ((q.size() > 0) && hd.we) || out_rd !== hd.rd ||
          out_mem_to_reg !== hd.m2r) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: valid=%b ready=%b we=%b rd=%0d m2r=%b, want %b %b %b %0d %b",
                 cyc, out_valid, in_ready, out_write_enable, out_rd, out_mem_to_reg,
                 q.size() > 0, q.size() < 2, (q.size() > 0) && hd.we, hd.rd, hd.m2r);
      end
      checks++;
      if (out_alu_out !== hd.alu || out_mem_out !== hd.mem || out_wb_data !== exp_wb) begin
        errors++;
        $display("FAIL rand_data@%0d: alu=%h mem=%h wb=%h, want %h %h %h",
                 cyc, out_alu_out, out_mem_out, out_wb_data, hd.alu, hd.mem, exp_wb);
      end
      e.alu = $urandom;
      e.mem = $urandom;
      e.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      e.m2r = 1'($urandom);
      e.we  = 1'($urandom);
      drive(($urandom_range(0, 9) < 7), e.alu, e.mem, e.rd, e.m2r, e.we);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      e.we = e.we && (e.rd != 5'd0);
      @(posedge clk);
      last = hd;
      if (flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_x0_write();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
